// File: rtl/nonce_sched_pkg.sv
// ============================================================================
// Module      : nonce_sched_pkg
// Description : Shared types, widths and chunk-end helper for nonce_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nonce_sched_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISPATCH  = 2'd1,
        ST_EXHAUSTED = 2'd2
    } sched_state_t;

    // Chunk end clamped to the job limit; the 33-bit sum keeps the carry out
    // of 0xFFFFFFFF visible so the top chunk saturates instead of wrapping.
    function automatic logic [NONCE_W-1:0] chunk_end_sat(
        input logic [NONCE_W-1:0] start,
        input logic [NONCE_W-1:0] limit,
        input int unsigned        log2
    );
        logic [NONCE_W:0] sum;
        sum = {1'b0, start} + ((NONCE_W+1)'(1) << log2) - (NONCE_W+1)'(1);
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[NONCE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; priority resumes just after last winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    // r_mask marks positions strictly above the last winner; all-zero means
    // the pointer has wrapped and plain lowest-index priority applies.
    logic [N-1:0] r_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_pick_src;
    logic [N-1:0] w_above;

    assign w_masked   = req & r_mask;
    assign w_pick_src = (|w_masked) ? w_masked : req;
    assign grant      = w_pick_src & (~w_pick_src + N'(1));
    assign w_above    = ~(grant | (grant - N'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '1;
        end else if (advance && (|grant)) begin
            r_mask <= w_above;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nonce_scheduler.sv
// ============================================================================
// Module      : nonce_scheduler
// Description : Splits a job nonce range into chunks for hashing cores and
//               funnels found golden nonces into rate-limited ticket pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_scheduler
    import nonce_sched_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 16,
    parameter int TICKET_GAP = 8
) (
    input  logic                           hash_clk,
    input  logic                           rst,
    input  logic                           new_work,
    input  logic [NONCE_W-1:0]             nonce_min,
    input  logic [NONCE_W-1:0]             nonce_max,
    input  logic [NUM_CORES-1:0]           core_req,
    output logic [NUM_CORES-1:0]           core_grant,
    output logic [NONCE_W-1:0]             chunk_start,
    output logic [NONCE_W-1:0]             chunk_end,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
    output logic [NUM_CORES-1:0]           core_found_ack,
    output logic                           new_golden_ticket,
    output logic [NONCE_W-1:0]             golden_nonce,
    output logic                           need_work
);

    localparam int c_GAP_W = $clog2(TICKET_GAP + 1);

    sched_state_t            r_state;
    sched_state_t            w_state_nxt;
    logic [NONCE_W-1:0]      r_next_nonce;
    logic [NONCE_W-1:0]      r_end_nonce;
    logic [NONCE_W-1:0]      w_chunk_end;
    logic                    w_grant_en;
    logic [NUM_CORES-1:0]    w_rr_grant;

    logic [c_GAP_W-1:0]      r_gap;
    logic                    r_ticket;
    logic [NONCE_W-1:0]      r_golden;
    logic                    w_ack_en;
    logic                    w_ack_any;
    logic [NUM_CORES-1:0]    w_found_grant;
    logic [NONCE_W-1:0]      w_lane_nonce [NUM_CORES];
    logic [NONCE_W-1:0]      w_sel_nonce;

    assign w_chunk_end = chunk_end_sat(r_next_nonce, r_end_nonce, CHUNK_LOG2);

    // ------------------------------------------------------------------
    // Chunk dispatch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        if (new_work) begin
            w_state_nxt = (nonce_min > nonce_max) ? ST_EXHAUSTED : ST_DISPATCH;
        end else begin
            case (r_state)
                ST_DISPATCH: begin
                    if (|core_req) begin
                        w_grant_en = !rst;
                        if (w_chunk_end == r_end_nonce) begin
                            w_state_nxt = ST_EXHAUSTED;
                        end
                    end
                end
                ST_IDLE, ST_EXHAUSTED: w_state_nxt = r_state;
                default:               w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign core_grant  = w_grant_en ? w_rr_grant    : '0;
    assign chunk_start = w_grant_en ? r_next_nonce  : '0;
    assign chunk_end   = w_grant_en ? w_chunk_end   : '0;
    assign need_work   = (r_state != ST_DISPATCH);

    always_ff @(posedge hash_clk) begin
        if (rst) begin
            r_next_nonce <= '0;
            r_end_nonce  <= '0;
        end else if (new_work) begin
            r_next_nonce <= nonce_min;
            r_end_nonce  <= nonce_max;
        end else if (w_grant_en) begin
            r_next_nonce <= w_chunk_end + NONCE_W'(1);
        end
    end

    rr_arbiter #(
        .N       (NUM_CORES)
    ) u_chunk_arb (
        .clk     (hash_clk),
        .rst     (rst),
        .req     (core_req),
        .advance (w_grant_en),
        .grant   (w_rr_grant)
    );

    // ------------------------------------------------------------------
    // Golden ticket path
    // ------------------------------------------------------------------
    // Blocking during the ticket cycle keeps a second ack from slipping in
    // before the gap counter is loaded.
    assign w_ack_en       = !rst && (r_gap == '0) && !r_ticket;
    assign core_found_ack = w_ack_en ? w_found_grant : '0;
    assign w_ack_any      = |core_found_ack;

    rr_arbiter #(
        .N       (NUM_CORES)
    ) u_ticket_arb (
        .clk     (hash_clk),
        .rst     (rst),
        .req     (core_found),
        .advance (w_ack_en),
        .grant   (w_found_grant)
    );

    generate
        for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce_lane
            assign w_lane_nonce[g] = {NONCE_W{core_found_ack[g]}}
                                   & core_nonce[g*NONCE_W +: NONCE_W];
        end
    endgenerate

    always_comb begin
        w_sel_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_sel_nonce = w_sel_nonce | w_lane_nonce[i];
        end
    end

    always_ff @(posedge hash_clk) begin
        if (rst) begin
            r_ticket <= 1'b0;
            r_golden <= '0;
            r_gap    <= '0;
        end else begin
            r_ticket <= w_ack_any;
            if (w_ack_any) begin
                r_golden <= w_sel_nonce;
            end
            if (r_ticket) begin
                r_gap <= c_GAP_W'(TICKET_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GAP_W'(1);
            end
        end
    end

    assign new_golden_ticket = r_ticket;
    assign golden_nonce      = r_golden;

endmodule

`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
// ============================================================================
// Module      : tb_nonce_scheduler
// Description : Directed self-checking bench for nonce_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_scheduler;

    localparam int c_NC  = 4;
    localparam int c_GAP = 8;

    logic              hash_clk = 1'b0;
    logic              rst;
    logic              new_work;
    logic [31:0]       nonce_min;
    logic [31:0]       nonce_max;
    logic [c_NC-1:0]   core_req;
    logic [c_NC-1:0]   core_grant;
    logic [31:0]       chunk_start;
    logic [31:0]       chunk_end;
    logic [c_NC-1:0]   core_found;
    logic [32*c_NC-1:0] core_nonce;
    logic [c_NC-1:0]   core_found_ack;
    logic              new_golden_ticket;
    logic [31:0]       golden_nonce;
    logic              need_work;

    int n_checks = 0;
    int n_fail   = 0;

    nonce_scheduler #(
        .NUM_CORES  (c_NC),
        .CHUNK_LOG2 (16),
        .TICKET_GAP (c_GAP)
    ) dut (
        .hash_clk          (hash_clk),
        .rst               (rst),
        .new_work          (new_work),
        .nonce_min         (nonce_min),
        .nonce_max         (nonce_max),
        .core_req          (core_req),
        .core_grant        (core_grant),
        .chunk_start       (chunk_start),
        .chunk_end         (chunk_end),
        .core_found        (core_found),
        .core_nonce        (core_nonce),
        .core_found_ack    (core_found_ack),
        .new_golden_ticket (new_golden_ticket),
        .golden_nonce      (golden_nonce),
        .need_work         (need_work)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g,
                                input logic [31:0] s, input logic [31:0] e);
        @(negedge hash_clk);
        check({tag, "_grant"}, 64'(core_grant), 64'(g));
        check({tag, "_start"}, 64'(chunk_start), 64'(s));
        check({tag, "_end"},   64'(chunk_end),   64'(e));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_need"},   64'(need_work),         64'd1);
        check({tag, "_grant"},  64'(core_grant),        64'd0);
        check({tag, "_ack"},    64'(core_found_ack),    64'd0);
        check({tag, "_ticket"}, 64'(new_golden_ticket), 64'd0);
        check({tag, "_golden"}, 64'(golden_nonce),      64'd0);
        check({tag, "_cstart"}, 64'(chunk_start),       64'd0);
        check({tag, "_cend"},   64'(chunk_end),         64'd0);
    endtask

    task automatic start_job(input logic [31:0] mn, input logic [31:0] mx, input string tag);
        new_work  = 1'b1;
        nonce_min = mn;
        nonce_max = mx;
        @(negedge hash_clk);
        check({tag, "_nw_nogrant"}, 64'(core_grant), 64'd0);
        step();
        new_work = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        rst        = 1'b1;
        new_work   = 1'b0;
        nonce_min  = '0;
        nonce_max  = '0;
        core_req   = '0;
        core_found = '0;
        core_nonce = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge hash_clk);
        check_reset_outputs("reset");
        step();

        // Three full chunks then exhaustion
        core_req = 4'b1111;
        start_job(32'h0, 32'h2FFFF, "job1");
        expect_grant("job1_c0", 4'b0001, 32'h00000, 32'h0FFFF);
        expect_grant("job1_c1", 4'b0010, 32'h10000, 32'h1FFFF);
        expect_grant("job1_c2", 4'b0100, 32'h20000, 32'h2FFFF);
        @(negedge hash_clk);
        check("job1_exh_grant", 64'(core_grant), 64'd0);
        check("job1_exh_need",  64'(need_work),  64'd1);
        step();

        // Top of nonce space: saturate, never wrap
        start_job(32'hFFFF8000, 32'hFFFFFFFF, "top");
        expect_grant("top_c", 4'b1000, 32'hFFFF8000, 32'hFFFFFFFF);
        @(negedge hash_clk);
        check("top_exh_grant", 64'(core_grant),  64'd0);
        check("top_exh_start", 64'(chunk_start), 64'd0);
        check("top_exh_need",  64'(need_work),   64'd1);
        step();

        // Inverted range goes straight to exhausted
        start_job(32'd5, 32'd4, "inv");
        @(negedge hash_clk);
        check("inv_need",  64'(need_work),  64'd1);
        check("inv_grant", 64'(core_grant), 64'd0);
        step();

        // New work arriving mid-dispatch
        start_job(32'h0, 32'h2FFFF, "mid");
        expect_grant("mid_c0", 4'b0001, 32'h0, 32'hFFFF);
        start_job(32'h1000, 32'hFFFFF, "mid2");
        expect_grant("mid_c1", 4'b0010, 32'h1000, 32'h10FFF);
        core_req = '0;

        // Two simultaneous finders, rate limited
        core_nonce[63:32] = 32'h38b9b05a;
        core_nonce[95:64] = 32'h11111111;
        core_found        = 4'b0110;
        @(negedge hash_clk);
        check("tk1_ack", 64'(core_found_ack), 64'b0010);
        step();
        core_found[1] = 1'b0;
        @(negedge hash_clk);
        check("tk1_ticket", 64'(new_golden_ticket), 64'd1);
        check("tk1_golden", 64'(golden_nonce),      64'h38b9b05a);
        check("tk1_noack",  64'(core_found_ack),    64'd0);
        cycles = 1;
        while (cycles < 40 && core_found_ack == '0) begin
            step();
            cycles++;
            @(negedge hash_clk);
        end
        check("tk2_ack", 64'(core_found_ack), 64'b0100);
        check("tk2_gap_ok", 64'(cycles >= c_GAP), 64'd1);
        step();
        core_found = '0;
        @(negedge hash_clk);
        check("tk2_ticket", 64'(new_golden_ticket), 64'd1);
        check("tk2_golden", 64'(golden_nonce),      64'h11111111);
        step();

        // Reset while dispatching with a finder pending
        core_req   = 4'b1111;
        core_found = 4'b0001;
        start_job(32'h0, 32'h2FFFF, "rst");
        rst = 1'b1;
        @(negedge hash_clk);
        check("rst_cycle_ack",   64'(core_found_ack), 64'd0);
        check("rst_cycle_grant", 64'(core_grant),     64'd0);
        step();
        rst        = 1'b0;
        core_found = '0;
        core_req   = '0;
        @(negedge hash_clk);
        check_reset_outputs("post_rst");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
